i2c_target: RTL and testbench
=============================

# i2c_target

Synchronous I2C target (slave) responding to one fixed 7-bit address. It lets the design be the responder on the bus that our I2C controller drives. SCL and SDA are oversampled on the 16 MHz system clock; the block detects START and STOP, matches the address, receives write bytes and returns read bytes. SDA is driven open-drain.

## Interface
- `ADDR`, default 7'h50: own 7-bit target address.
- `clk` in 1: 16 MHz system clock; everything is on its rising edge.
- `rst` in 1: synchronous, active-low reset.
- `SCL` in 1: bus clock. Input only; no clock stretching.
- `SDA` inout 1: bus data, open-drain. Drives `1'b0` or `1'bz`, never `1`.
- `txData` in 8: byte to return on a read. Latched when `txReq` pulses.
- `txReq` out 1: one-cycle pulse when `txData` is latched. The host may then present the next byte.
- `rxData` out 8: last byte received in a write.
- `rxValid` out 1: one-cycle pulse when `rxData` updates.
- `busy` out 1: high from any START until STOP.
- `rw` out 1: R/W bit of the last matched address. 1 = read.

## Operation
- **Input conditioning**
  - SCL and SDA each pass through a 2-flop synchronizer, then a third flop for edge detect.
  - Rise and fall events are single-cycle strobes.
- **Bus conditions**
  - START: SDA falls while SCL is high.
  - STOP: SDA rises while SCL is high.
  - Both have priority over every state.
  - START (including a repeated START): go to ADDR, clear the bit counter, release SDA, set `busy`=1.
  - STOP: go to IDLE, release SDA, set `busy`=0.
- **Bit timing**
  - Data bits are sampled on the SCL rise strobe.
  - SDA changes on the SCL fall strobe.
  - Bytes are MSB first.
- **States**
  - IDLE: SDA released. Leave only on START.
  - ADDR: shift 8 bits.
    - After the 8th rise, if bits[7:1]==ADDR: record `rw` and go to ADDR_ACK.
    - Otherwise go to IDLE and ignore the bus until the next START.
  - ADDR_ACK:
    - At the next fall, drive SDA low.
    - At the following fall:
      - Write: release SDA and go to RX.
      - Read: latch `txData`, pulse `txReq`, drive bit 7 and go to TX.
  - RX: shift 8 bits.
    - On the 8th rise, update `rxData` and pulse `rxValid` in the same cycle.
    - Then go to RX_ACK.
  - RX_ACK: drive SDA low at the next fall, release it at the following fall, return to RX. The byte count is unlimited.
  - TX: drive the current bit at each fall. After bit 0's clock, release SDA at the next fall and go to TX_ACK.
  - TX_ACK: sample the controller's bit on the rise.
    - ACK (0): at the next fall, latch `txData`, pulse `txReq`, drive bit 7 and go to TX.
    - NACK (1): go to IDLE with SDA released. `busy` stays 1 until STOP.
- **General call**: address 0 is not supported; it is treated as a mismatch.
- **Reset**: `rst`=0 with the clock running gives, on the next edge:
  - SDA released; synchronizer flops set to 1.
  - State IDLE.
  - `rxData`=0, `rxValid`=0, `txReq`=0, `busy`=0, `rw`=0.
  - Applies even if reset arrives mid-byte or while driving ACK.

## Timing
- Pin edge to internal strobe: 3 clk.
  - SDA is driven/released 3 clk after an SCL fall, 4 clk after reset deasserts.
  - `rxValid` rises 3 clk after the 8th SCL rise.
- Bus requirements:
  - SCL low and high phases each ≥ 4 clk.
  - Controller SDA changes ≥ 1 clk away from SCL edges.
  - START/STOP: SDA edge ≥ 1 clk inside the SCL-high window.
- `txData` must be stable from `txReq` until the next SCL fall. The latched copy is used for the whole byte.
- `rxValid` and `txReq` are exactly one clk wide.

## Test plan
1. **Write**: START, 0xA0, 0x5A, STOP at SCL half-period 6 clk.
   - Target ACKs both bytes.
   - `rxData`=0x5A with a single `rxValid` pulse.
   - `busy` is 1 between START and STOP, then 0.
2. **Address mismatch**: START, 0xA4, 0x77.
   - SDA is never pulled low; no `rxValid`.
   - A following START, 0xA0 is ACKed.
3. **Two-byte read**: `txData`=0xC3 for byte 1, then 0x3C after `txReq`; START, 0xA1.
   - Controller sees ACK, then 0xC3; controller ACKs.
   - Controller then sees 0x3C; controller NACKs.
   - Target releases SDA; STOP sets `busy`=0.
   - Exactly two `txReq` pulses.
4. **Repeated START**: write 0x11, then Sr, 0xA1 with `txData`=0x96.
   - `rxData`=0x11; read returns 0x96; `rw`=1 after Sr.
5. **Reset mid-ACK**: assert `rst` while the target drives ACK.
   - SDA released and all outputs 0 on the next clk.
   - The remaining bits are ignored until a fresh START.
6. **Minimum timing**: SCL half-period 4 clk, write 0xFF then read 0x00.
   - All bits and ACKs are correct.
   - No false START or STOP detected.

Source files
------------

// File: rtl/i2c_target.sv
// rtl/i2c_target.sv - I2C target (slave) responding to one fixed 7-bit address
//
// Ports:
//   clk     in  : system clock, all logic on its rising edge
//   rst     in  : synchronous active-low reset
//   SCL     in  : bus clock (no stretching)
//   SDA     io  : bus data, open-drain (drives 0 or z only)
//   txData  in  : byte returned on a read, latched when txReq pulses
//   txReq   out : one-cycle pulse when txData has been latched
//   rxData  out : last byte received in a write
//   rxValid out : one-cycle pulse when rxData updates
//   busy    out : high from any START until STOP
//   rw      out : R/W bit of the last matched address (1 = read)
module i2c_target #(
    parameter logic [6:0] ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       SCL,
    inout  wire        SDA,
    input  logic [7:0] txData,
    output logic       txReq,
    output logic [7:0] rxData,
    output logic       rxValid,
    output logic       busy,
    output logic       rw
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_RX       = 3'd3;
    localparam logic [2:0] S_RX_ACK   = 3'd4;
    localparam logic [2:0] S_TX       = 3'd5;
    localparam logic [2:0] S_TX_ACK   = 3'd6;

    logic       r_scl_s1, r_scl_s2, r_scl_d;
    logic       r_sda_s1, r_sda_s2, r_sda_d;
    logic [2:0] r_state;
    logic [2:0] r_bit_cnt;
    logic [6:0] r_shift;     // first seven bits of the byte being received
    logic [6:0] r_tx_sh;     // bits still to send after the one on the bus
    logic       r_ack_phase; // 0: next fall drives ACK, 1: next fall ends ACK
    logic       r_nack;
    logic       r_sda_oe;

    wire w_scl_rise = r_scl_s2 & ~r_scl_d;
    wire w_scl_fall = ~r_scl_s2 & r_scl_d;
    wire w_sda_rise = r_sda_s2 & ~r_sda_d;
    wire w_sda_fall = ~r_sda_s2 & r_sda_d;
    // SCL must be steadily high on both sides of the SDA edge
    wire w_start    = w_sda_fall & r_scl_s2 & r_scl_d;
    wire w_stop     = w_sda_rise & r_scl_s2 & r_scl_d;
    wire w_addr_hit = (r_shift == ADDR) && (r_shift != 7'd0);

    assign SDA = r_sda_oe ? 1'b0 : 1'bz;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_scl_s1    <= 1'b1;
            r_scl_s2    <= 1'b1;
            r_scl_d     <= 1'b1;
            r_sda_s1    <= 1'b1;
            r_sda_s2    <= 1'b1;
            r_sda_d     <= 1'b1;
            r_state     <= S_IDLE;
            r_bit_cnt   <= 3'd0;
            r_shift     <= 7'd0;
            r_tx_sh     <= 7'd0;
            r_ack_phase <= 1'b0;
            r_nack      <= 1'b0;
            r_sda_oe    <= 1'b0;
            rxData      <= 8'd0;
            rxValid     <= 1'b0;
            txReq       <= 1'b0;
            busy        <= 1'b0;
            rw          <= 1'b0;
        end else begin
            r_scl_s1 <= SCL;
            r_scl_s2 <= r_scl_s1;
            r_scl_d  <= r_scl_s2;
            r_sda_s1 <= SDA;
            r_sda_s2 <= r_sda_s1;
            r_sda_d  <= r_sda_s2;
            rxValid  <= 1'b0;
            txReq    <= 1'b0;

            if (w_start) begin
                r_state   <= S_ADDR;
                r_bit_cnt <= 3'd0;
                r_sda_oe  <= 1'b0;
                busy      <= 1'b1;
            end else if (w_stop) begin
                r_state  <= S_IDLE;
                r_sda_oe <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                    end
                    S_ADDR: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[5:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                // r_shift holds address bits, the incoming bit is R/W
                                if (w_addr_hit) begin
                                    rw          <= r_sda_s2;
                                    r_ack_phase <= 1'b0;
                                    r_state     <= S_ADDR_ACK;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_oe    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else if (!rw) begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_RX;
                            end else begin
                                r_tx_sh   <= txData[6:0];
                                txReq     <= 1'b1;
                                r_sda_oe  <= ~txData[7];
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_TX;
                            end
                        end
                    end
                    S_RX: begin
                        if (w_scl_rise) begin
                            r_shift   <= {r_shift[5:0], r_sda_s2};
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                rxData      <= {r_shift, r_sda_s2};
                                rxValid     <= 1'b1;
                                r_ack_phase <= 1'b0;
                                r_state     <= S_RX_ACK;
                            end
                        end
                    end
                    S_RX_ACK: begin
                        if (w_scl_fall) begin
                            if (!r_ack_phase) begin
                                r_sda_oe    <= 1'b1;
                                r_ack_phase <= 1'b1;
                            end else begin
                                r_sda_oe  <= 1'b0;
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_RX;
                            end
                        end
                    end
                    S_TX: begin
                        // bit 7 went out on entry; each fall presents the next bit
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 3'd7) begin
                                r_sda_oe <= 1'b0;
                                r_state  <= S_TX_ACK;
                            end else begin
                                r_sda_oe  <= ~r_tx_sh[6];
                                r_tx_sh   <= {r_tx_sh[5:0], 1'b0};
                                r_bit_cnt <= r_bit_cnt + 3'd1;
                            end
                        end
                    end
                    S_TX_ACK: begin
                        if (w_scl_rise) begin
                            r_nack <= r_sda_s2;
                        end else if (w_scl_fall) begin
                            if (r_nack) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_tx_sh   <= txData[6:0];
                                txReq     <= 1'b1;
                                r_sda_oe  <= ~txData[7];
                                r_bit_cnt <= 3'd0;
                                r_state   <= S_TX;
                            end
                        end
                    end
                    default: begin
                        r_state  <= S_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_target.sv
// tb/tb_i2c_target.sv - bench for i2c_target: bus controller model with scoreboard
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] OWN_ADDR = 7'h50;

    logic       clk = 1'b0;
    logic       rst;
    logic       r_scl;
    logic       r_sda_low;
    logic [7:0] txData;
    wire        SDA;
    wire        txReq;
    wire  [7:0] rxData;
    wire        rxValid;
    wire        busy;
    wire        rw;

    pullup (SDA);
    assign SDA = r_sda_low ? 1'b0 : 1'bz;

    always #31.25 clk = ~clk;

    i2c_target #(.ADDR(OWN_ADDR)) dut (
        .clk(clk), .rst(rst), .SCL(r_scl), .SDA(SDA),
        .txData(txData), .txReq(txReq), .rxData(rxData),
        .rxValid(rxValid), .busy(busy), .rw(rw)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int hp = 6;
    int cyc = 0;
    int rxv_cnt = 0;
    int txr_cnt = 0;
    int dut_low_cnt = 0;
    int busy_fall_cnt = 0;
    int rxv_cyc = -1;
    int last_rise_cyc = 0;
    logic busy_q = 1'b0;
    logic [7:0] m_rx = 8'h00;
    logic [7:0] tx_q[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rxValid === 1'b1) begin
            rxv_cnt++;
            rxv_cyc = cyc;
        end
        if (txReq === 1'b1) txr_cnt++;
        if (SDA === 1'b0 && !r_sda_low) dut_low_cnt++;
        if (busy_q === 1'b1 && busy === 1'b0) busy_fall_cnt++;
        busy_q = busy;
    end

    // Reference rule: a byte is ACKed when its address field names us and is not general call
    function automatic logic model_match(input logic [7:0] b);
        return (b[7:1] == OWN_ADDR) && (b[7:1] != 7'd0);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered with SCL just fallen; leaves with SCL just fallen
    task automatic do_bit(input logic drive_low, output logic seen);
        tick(1); r_sda_low = drive_low;
        tick(hp - 1); r_scl = 1'b1; last_rise_cyc = cyc;
        tick(hp / 2); seen = SDA;
        tick(hp - hp / 2); r_scl = 1'b0;
    endtask

    task automatic start_cond;
        if (r_scl == 1'b0) begin
            tick(1); r_sda_low = 1'b0;
            tick(hp - 1); r_scl = 1'b1;
            tick(hp);
        end else begin
            r_sda_low = 1'b0;
            tick(hp);
        end
        r_sda_low = 1'b1;
        tick(hp); r_scl = 1'b0;
    endtask

    task automatic stop_cond;
        tick(1); r_sda_low = 1'b1;
        tick(hp - 1); r_scl = 1'b1;
        tick(hp); r_sda_low = 1'b0;
        tick(hp);
    endtask

    // Eight data bits then the ACK clock; sda_pre/sda_post are SDA 2 and 3 clk after the 8th fall
    task automatic write_byte(input logic [7:0] b, output logic ack_seen,
                              output logic sda_pre, output logic sda_post);
        logic s;
        for (int i = 7; i >= 0; i--) do_bit(~b[i], s);
        tick(1); r_sda_low = 1'b0;
        tick(1); sda_pre = SDA;
        tick(1); sda_post = SDA;
        tick(hp - 3); r_scl = 1'b1;
        tick(hp / 2); ack_seen = SDA;
        tick(hp - hp / 2); r_scl = 1'b0;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] v);
        logic s;
        v = 8'h00;
        for (int i = 0; i < 8; i++) begin
            do_bit(1'b0, s);
            v = {v[6:0], s};
        end
        if (tx_q.size() > 0) txData = tx_q.pop_front();
        do_bit(ack, s);
    endtask

    task automatic test_reset;
        rst = 1'b0; r_scl = 1'b1; r_sda_low = 1'b0; txData = 8'h00;
        tick(3);
        n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want 1", SDA); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (rxValid !== 1'b0) begin n_bad++; $display("FAIL reset_rxvalid: got %b want 0", rxValid); end
        n_cmp++; if (txReq !== 1'b0) begin n_bad++; $display("FAIL reset_txreq: got %b want 0", txReq); end
        n_cmp++; if (rxData !== 8'h00) begin n_bad++; $display("FAIL reset_rxdata: got %h want 00", rxData); end
        n_cmp++; if (rw !== 1'b0) begin n_bad++; $display("FAIL reset_rw: got %b want 0", rw); end
        rst = 1'b1;
        tick(4);
    endtask

    task automatic test_write;
        logic a, pre, post;
        hp = 6; rxv_cnt = 0;
        start_cond;
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_start: got %b want 1", busy); end
        write_byte(8'hA0, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL wr_addr_ack: got %b want 0", a); end
        n_cmp++; if (pre !== 1'b1) begin n_bad++; $display("FAIL wr_ack_early: got %b want 1", pre); end
        n_cmp++; if (post !== 1'b0) begin n_bad++; $display("FAIL wr_ack_latency: got %b want 0", post); end
        rxv_cyc = -1;
        write_byte(8'h5A, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL wr_data_ack: got %b want 0", a); end
        n_cmp++; if (rxv_cyc != last_rise_cyc + 3) begin n_bad++; $display("FAIL wr_rxvalid_latency: got %0d want %0d", rxv_cyc - last_rise_cyc, 3); end
        n_cmp++; if (rxData !== 8'h5A) begin n_bad++; $display("FAIL wr_rxdata: got %h want 5a", rxData); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL wr_busy_mid: got %b want 1", busy); end
        stop_cond;
        m_rx = 8'h5A;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL wr_busy_stop: got %b want 0", busy); end
        n_cmp++; if (rxv_cnt != 1) begin n_bad++; $display("FAIL wr_rxvalid_count: got %0d want 1", rxv_cnt); end
    endtask

    task automatic test_mismatch;
        logic a, pre, post;
        logic [7:0] ab;
        hp = 5; dut_low_cnt = 0; rxv_cnt = 0;
        start_cond;
        write_byte(8'hA4, a, pre, post);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL mm_addr_nack: got %b want 1", a); end
        write_byte(8'h77, a, pre, post);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL mm_data_nack: got %b want 1", a); end
        for (int k = 0; k < 3; k++) begin
            ab = 8'($urandom);
            if (k == 0) ab[7:1] = 7'd0;
            else if (ab[7:1] == OWN_ADDR) ab[7:1] = OWN_ADDR ^ 7'h01;
            start_cond;
            write_byte(ab, a, pre, post);
            n_cmp++; if (a !== !model_match(ab)) begin n_bad++; $display("FAIL mm_rand_addr %h: got %b want %b", ab, a, !model_match(ab)); end
        end
        n_cmp++; if (dut_low_cnt != 0) begin n_bad++; $display("FAIL mm_sda_pulled: got %0d cycles want 0", dut_low_cnt); end
        n_cmp++; if (rxv_cnt != 0) begin n_bad++; $display("FAIL mm_rxvalid: got %0d want 0", rxv_cnt); end
        start_cond;
        write_byte(8'hA0, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL mm_recover_ack: got %b want 0", a); end
        stop_cond;
    endtask

    task automatic test_read;
        logic a, pre, post;
        logic [7:0] v;
        hp = 6; txr_cnt = 0;
        tx_q = '{8'hC3, 8'h3C};
        txData = tx_q.pop_front();
        start_cond;
        write_byte(8'hA1, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL rd_addr_ack: got %b want 0", a); end
        read_byte(1'b1, v);
        n_cmp++; if (v !== 8'hC3) begin n_bad++; $display("FAIL rd_byte0: got %h want c3", v); end
        read_byte(1'b0, v);
        n_cmp++; if (v !== 8'h3C) begin n_bad++; $display("FAIL rd_byte1: got %h want 3c", v); end
        tick(4);
        n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL rd_release_after_nack: got %b want 1", SDA); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rd_busy_after_nack: got %b want 1", busy); end
        stop_cond;
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rd_busy_stop: got %b want 0", busy); end
        n_cmp++; if (txr_cnt != 2) begin n_bad++; $display("FAIL rd_txreq_count: got %0d want 2", txr_cnt); end
        n_cmp++; if (rw !== 1'b1) begin n_bad++; $display("FAIL rd_rw: got %b want 1", rw); end
    endtask

    task automatic test_repeated_start;
        logic a, pre, post;
        logic [7:0] v;
        hp = 6;
        start_cond;
        write_byte(8'hA0, a, pre, post);
        write_byte(8'h11, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL sr_write_ack: got %b want 0", a); end
        m_rx = 8'h11;
        tx_q = '{8'h96};
        txData = tx_q.pop_front();
        start_cond;
        n_cmp++; if (rxData !== m_rx) begin n_bad++; $display("FAIL sr_rxdata: got %h want %h", rxData, m_rx); end
        write_byte(8'hA1, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL sr_read_ack: got %b want 0", a); end
        n_cmp++; if (rw !== 1'b1) begin n_bad++; $display("FAIL sr_rw: got %b want 1", rw); end
        read_byte(1'b0, v);
        n_cmp++; if (v !== 8'h96) begin n_bad++; $display("FAIL sr_read_data: got %h want 96", v); end
        stop_cond;
    endtask

    task automatic test_reset_mid_ack;
        logic a, pre, post, s;
        logic [7:0] b;
        hp = 6;
        tx_q.delete();
        txData = 8'($urandom);
        b = 8'hA1;
        start_cond;
        for (int i = 7; i >= 0; i--) do_bit(~b[i], s);
        tick(1); r_sda_low = 1'b0;
        tick(hp - 1); r_scl = 1'b1;
        tick(1);
        n_cmp++; if (SDA !== 1'b0) begin n_bad++; $display("FAIL rm_ack_driven: got %b want 0", SDA); end
        rst = 1'b0;
        tick(1);
        n_cmp++; if (SDA !== 1'b1) begin n_bad++; $display("FAIL rm_sda: got %b want 1", SDA); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rm_busy: got %b want 0", busy); end
        n_cmp++; if (rw !== 1'b0) begin n_bad++; $display("FAIL rm_rw: got %b want 0", rw); end
        n_cmp++; if (rxData !== 8'h00) begin n_bad++; $display("FAIL rm_rxdata: got %h want 00", rxData); end
        n_cmp++; if (rxValid !== 1'b0 || txReq !== 1'b0) begin n_bad++; $display("FAIL rm_pulses: got %b%b want 00", rxValid, txReq); end
        rst = 1'b1;
        m_rx = 8'h00;
        tick(hp - 2); r_scl = 1'b0;
        dut_low_cnt = 0; rxv_cnt = 0; txr_cnt = 0;
        write_byte(8'($urandom), a, pre, post);
        n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL rm_ignored_nack: got %b want 1", a); end
        n_cmp++; if (dut_low_cnt != 0 || rxv_cnt != 0 || txr_cnt != 0) begin n_bad++; $display("FAIL rm_ignored_activity: got %0d/%0d/%0d want 0/0/0", dut_low_cnt, rxv_cnt, txr_cnt); end
        start_cond;
        write_byte(8'hA0, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL rm_fresh_ack: got %b want 0", a); end
        stop_cond;
    endtask

    task automatic test_min_timing;
        logic a, pre, post;
        logic [7:0] v;
        hp = 4; busy_fall_cnt = 0; rxv_cnt = 0; txr_cnt = 0;
        start_cond;
        write_byte(8'hA0, a, pre, post);
        n_cmp++; if (a !== 1'b0 || pre !== 1'b1 || post !== 1'b0) begin n_bad++; $display("FAIL mt_addr_ack: got %b%b%b want 010", a, pre, post); end
        write_byte(8'hFF, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL mt_data_ack: got %b want 0", a); end
        n_cmp++; if (rxData !== 8'hFF) begin n_bad++; $display("FAIL mt_rxdata: got %h want ff", rxData); end
        stop_cond;
        m_rx = 8'hFF;
        tx_q = '{8'h00};
        txData = tx_q.pop_front();
        start_cond;
        write_byte(8'hA1, a, pre, post);
        n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL mt_read_ack: got %b want 0", a); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mt_busy_held: got %b want 1", busy); end
        read_byte(1'b0, v);
        n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL mt_read_data: got %h want 00", v); end
        stop_cond;
        n_cmp++; if (busy_fall_cnt != 2) begin n_bad++; $display("FAIL mt_busy_falls: got %0d want 2", busy_fall_cnt); end
        n_cmp++; if (rxv_cnt != 1 || txr_cnt != 1) begin n_bad++; $display("FAIL mt_pulses: got %0d/%0d want 1/1", rxv_cnt, txr_cnt); end
    endtask

    task automatic test_random;
        logic a, pre, post, match, is_read;
        logic [7:0] ab, d, v;
        logic [7:0] exp_q[$];
        int n;
        for (int t = 0; t < 6; t++) begin
            hp = $urandom_range(4, 8);
            is_read = 1'($urandom_range(0, 1));
            n = $urandom_range(1, 3);
            ab = 8'($urandom);
            ab[0] = is_read;
            if ($urandom_range(0, 3) != 0) ab[7:1] = OWN_ADDR;
            else if (ab[7:1] == OWN_ADDR) ab[7:1] = ~OWN_ADDR;
            match = model_match(ab);
            rxv_cnt = 0; txr_cnt = 0;
            exp_q.delete();
            for (int k = 0; k < n; k++) exp_q.push_back(8'($urandom));
            tx_q = exp_q;
            txData = tx_q.pop_front();
            start_cond;
            write_byte(ab, a, pre, post);
            n_cmp++; if (a !== !match) begin n_bad++; $display("FAIL rnd_addr_ack %h: got %b want %b", ab, a, !match); end
            if (!is_read) begin
                for (int k = 0; k < n; k++) begin
                    d = exp_q[k];
                    write_byte(d, a, pre, post);
                    if (match) m_rx = d;
                    n_cmp++; if (a !== !match) begin n_bad++; $display("FAIL rnd_wr_ack %0d: got %b want %b", k, a, !match); end
                end
                stop_cond;
                n_cmp++; if (rxData !== m_rx) begin n_bad++; $display("FAIL rnd_rxdata: got %h want %h", rxData, m_rx); end
                n_cmp++; if (rxv_cnt != (match ? n : 0)) begin n_bad++; $display("FAIL rnd_rxvalid_count: got %0d want %0d", rxv_cnt, match ? n : 0); end
            end else begin
                if (match) begin
                    for (int k = 0; k < n; k++) begin
                        read_byte(k < n - 1, v);
                        n_cmp++; if (v !== exp_q[k]) begin n_bad++; $display("FAIL rnd_rd_data %0d: got %h want %h", k, v, exp_q[k]); end
                    end
                end
                stop_cond;
                n_cmp++; if (txr_cnt != (match ? n : 0)) begin n_bad++; $display("FAIL rnd_txreq_count: got %0d want %0d", txr_cnt, match ? n : 0); end
            end
            n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rnd_busy_stop: got %b want 0", busy); end
        end
    endtask

    initial begin
        test_reset;
        test_write;
        test_mismatch;
        test_read;
        test_repeated_start;
        test_reset_mid_ack;
        test_min_timing;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
